// File: rtl/therm_pkg.sv
// Shared types and helpers for the thermometer-to-race-logic transmitter.
package therm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Bits needed to hold a count of 0..width ones.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/therm_to_bin.sv
// Combinational thermometer decoder: popcount plus bubble detection.
module therm_to_bin
    import therm_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] therm,
    output logic [CNT_W-1:0] count,
    output logic             bubble
);

    // A bubble is any one sitting above a zero.
    always_comb begin
        count  = '0;
        bubble = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            count = count + CNT_W'(therm[i]);
        end
        for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
            if (therm[i+1] && !therm[i]) begin
                bubble = 1'b1;
            end
        end
    end

endmodule

// File: rtl/therm_race_tx.sv
// Accepts one thermometer code per handshake and emits a race-logic edge
// k slots into a WIDTH+1 slot frame.
module therm_race_tx
    import therm_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] therm,
    output logic             race,
    output logic             frame,
    output logic [CNT_W-1:0] value,
    output logic             err
);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] slot;
    logic [CNT_W-1:0] slot_nxt;
    logic [CNT_W-1:0] value_nxt;
    logic             race_nxt;
    logic             frame_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] count;
    logic             bubble;
    logic             take;

    therm_to_bin #(
        .WIDTH(WIDTH)
    ) u_decode (
        .therm (therm),
        .count (count),
        .bubble(bubble)
    );

    assign in_ready = (state == IDLE);
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take && !bubble) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (slot == LAST_SLOT) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; race is high once the slot reaches k.
    always_comb begin
        slot_nxt  = slot;
        value_nxt = value;
        race_nxt  = 1'b0;
        frame_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    if (bubble) begin
                        err_nxt = 1'b1;
                    end else begin
                        value_nxt = count;
                        slot_nxt  = '0;
                        frame_nxt = 1'b1;
                        race_nxt  = (count == '0);
                    end
                end
            end
            SEND: begin
                if (slot != LAST_SLOT) begin
                    slot_nxt  = slot + CNT_W'(1);
                    frame_nxt = 1'b1;
                    race_nxt  = ((slot + CNT_W'(1)) >= value);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot  <= '0;
            value <= '0;
            race  <= 1'b0;
            frame <= 1'b0;
            err   <= 1'b0;
        end else begin
            slot  <= slot_nxt;
            value <= value_nxt;
            race  <= race_nxt;
            frame <= frame_nxt;
            err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_therm_race_tx.sv
// Directed bench for therm_race_tx with hand-computed frame expectations.
module tb_therm_race_tx;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] therm;
    logic             race;
    logic             frame;
    logic [CNT_W-1:0] value;
    logic             err;

    int total = 0;
    int bad   = 0;

    therm_race_tx #(
        .WIDTH(WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .therm   (therm),
        .race    (race),
        .frame   (frame),
        .value   (value),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a valid code for one edge, then check every slot and the guard cycle.
    task automatic send_frame(input logic [WIDTH-1:0] code, input int k, input string tag);
        in_valid = 1'b1;
        therm    = code;
        tick();
        in_valid = 1'b0;
        for (int s = 0; s <= int'(WIDTH); s++) begin
            check($sformatf("%s frame s%0d", tag, s), int'(frame), 1);
            check($sformatf("%s race s%0d", tag, s), int'(race), (s >= k) ? 1 : 0);
            check($sformatf("%s ready s%0d", tag, s), int'(in_ready), 0);
            check($sformatf("%s value s%0d", tag, s), int'(value), k);
            check($sformatf("%s err s%0d", tag, s), int'(err), 0);
            tick();
        end
        check({tag, " frame guard"}, int'(frame), 0);
        check({tag, " race guard"}, int'(race), 0);
        check({tag, " ready guard"}, int'(in_ready), 1);
        check({tag, " value hold"}, int'(value), k);
    endtask

    // A bubbled code: err for one cycle, nothing else moves.
    task automatic send_bubble(input logic [WIDTH-1:0] code, input int prev_value, input string tag);
        in_valid = 1'b1;
        therm    = code;
        tick();
        in_valid = 1'b0;
        check({tag, " err"}, int'(err), 1);
        check({tag, " frame"}, int'(frame), 0);
        check({tag, " race"}, int'(race), 0);
        check({tag, " ready"}, int'(in_ready), 1);
        check({tag, " value"}, int'(value), prev_value);
        tick();
        check({tag, " err drop"}, int'(err), 0);
        check({tag, " frame after"}, int'(frame), 0);
    endtask

    initial begin
        logic exp_frame [12];
        logic exp_race  [12];

        rst      = 1'b1;
        in_valid = 1'b1;
        therm    = 4'b0011;
        repeat (3) tick();
        check("rst race", int'(race), 0);
        check("rst frame", int'(frame), 0);
        check("rst err", int'(err), 0);
        check("rst value", int'(value), 0);
        check("rst ready", int'(in_ready), 1);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post rst frame", int'(frame), 0);
        check("post rst value", int'(value), 0);

        send_frame(4'b0011, 2, "k2");
        send_frame(4'b0000, 0, "k0");
        send_frame(4'b1111, 4, "k4");
        send_frame(4'b0001, 1, "k1");

        send_bubble(4'b1000, 1, "bub1000");
        send_bubble(4'b0101, 1, "bub0101");

        // Held valid: 0001 accepted at T, 0111 at T+6; cycles T+1..T+12.
        exp_frame = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_race  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        in_valid = 1'b1;
        therm    = 4'b0001;
        tick();
        therm = 4'b0111;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("b2b frame c%0d", c + 1), int'(frame), int'(exp_frame[c]));
            check($sformatf("b2b race c%0d", c + 1), int'(race), int'(exp_race[c]));
            if (c == 6) begin
                check("b2b value2", int'(value), 3);
                in_valid = 1'b0;
            end
            tick();
        end
        check("b2b ready end", int'(in_ready), 1);

        // Reset in slot 2 of a k=1 frame, checked before the next edge.
        in_valid = 1'b1;
        therm    = 4'b0001;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("abort pre frame", int'(frame), 1);
        check("abort pre race", int'(race), 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort frame", int'(frame), 0);
        check("abort race", int'(race), 0);
        check("abort err", int'(err), 0);
        check("abort ready", int'(in_ready), 1);
        tick();
        rst = 1'b0;
        tick();
        check("abort idle frame", int'(frame), 0);
        check("abort idle err", int'(err), 0);
        send_frame(4'b0011, 2, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/therm_race_tx.md
# therm_race_tx

Race-logic transmitter for thermometer-coded values. It accepts one WIDTH-bit thermometer code per valid/ready handshake, checks it for bubbles, and converts it to the count k of ones. It then emits a single race-logic line whose rising edge falls k cycles into a fixed-length frame. It sits after nBitThermMinMax-style sorting elements and drives their results onto a temporal (edge-time) link toward downstream race-logic stages.

## Interface
- WIDTH, 4, thermometer code width; a frame lasts WIDTH+1 cycles.
- CNT_W, $clog2(WIDTH+1), width of the binary count (3 for WIDTH=4).

- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  therm is presented.
- in_ready  out  1  block can accept a code; high only in IDLE.
- therm  in  WIDTH  thermometer code, LSB-aligned (0011 = 2).
- race  out  1  race-logic line, registered.
- frame  out  1  high for every slot of an active frame, registered.
- value  out  CNT_W  binary count of the frame in flight; holds its last value when idle.
- err  out  1  one-cycle pulse when an accepted code has a bubble.

## Operation
- FSM has two states: IDLE and SEND. in_ready = (state == IDLE).
- Transfer condition: in_valid && in_ready at a rising edge (cycle T) while rst is low.
- Valid code: therm[i+1] implies therm[i] for all i. Then k = popcount(therm), ranging 0..WIDTH.
- On a valid transfer:
  - register k into value and clear the slot counter to 0;
  - go to SEND.
- In SEND, for slot s = 0..WIDTH:
  - frame = 1;
  - race = (s >= k);
  - after slot WIDTH, return to IDLE with race = 0 and frame = 0.
- On an invalid transfer:
  - err = 1 for cycle T+1;
  - stay in IDLE; no frame is sent; value is unchanged.
- The slot counter is CNT_W bits wide and never wraps within a frame. Terminal slot is s == WIDTH.
- Reset values: race 0, frame 0, err 0, value 0, state IDLE (so in_ready = 1). Transfers are ignored while rst is high.
- Reset mid-frame aborts the frame immediately and asynchronously: race and frame drop low, no err pulse. The next accepted code after rst deasserts starts a clean frame.

## Timing
- Accept at edge T → frame high in cycles T+1 .. T+WIDTH+1.
- race rises at cycle T+1+k and stays high through T+WIDTH+1.
- in_ready is low in cycles T+1 .. T+WIDTH+1 and high again at T+WIDTH+2.
- That one guaranteed idle (guard) cycle separates frames, so back-to-back throughput is one code per WIDTH+2 cycles.
- k = 0: race is high for the whole frame. k = WIDTH: race is high only in the last slot.
- err latency is 1 cycle. in_ready stays high across an error, so a new code can be accepted at T+1.
- in_valid held high across frame end: the next code is accepted at the first edge where in_ready = 1.

## Structure
- Package therm_pkg holds:
  - the state enum (IDLE, SEND);
  - a function that computes CNT_W from WIDTH.
- Sub-module therm_to_bin (combinational, parameter WIDTH):
  - input: therm;
  - outputs: count (CNT_W bits) and bubble flag.
- therm_race_tx instantiates therm_to_bin and contains the FSM, slot counter and output registers.

## Test plan
- Reset: assert rst for 3 cycles → race = 0, frame = 0, err = 0, value = 0, in_ready = 1; in_valid with 0011 during reset is not accepted.
- therm = 0011 accepted at T → value = 2; frame high T+1..T+5; race high T+3..T+5; in_ready low T+1..T+5 and 1 at T+6.
- Boundary codes:
  - 0000 → race high T+1..T+5;
  - 1111 → race high only at T+5;
  - in both cases frame is identical (T+1..T+5).
- Bubble 1000 (also 0101) → err pulses at T+1 only; frame and race stay 0; in_ready stays 1; value unchanged.
- in_valid held high with 0001 then 0111 → second code accepted at T+6; exactly one idle cycle (frame = 0) between the two frames; race edges at T+2 and T+10.
- rst pulsed in slot 2 of a 0001 frame → race and frame drop without waiting for a clock edge; no err pulse. After release, 0011 produces a correct frame.
